acc_operand_feeder: RTL and testbench



---
 rtl/acc_operand_feeder.sv | 121 ++++++++++++
 tb/tb_acc_operand_feeder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_operand_feeder.sv
// Operand sequencing stage ahead of the 8-bit accumulator. Operands are queued
// in a small FIFO and a start command releases a programmed number of them, at
// most one per cycle. Every cycle without an issue drives 0 so the sum holds.
module acc_operand_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  input  logic             i_start,
  input  logic [7:0]       i_len,
  output logic [WIDTH-1:0] o_a,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_bubbles
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [7:0]       remaining, remaining_d;
  logic [7:0]       bubbles_d;
  logic [WIDTH-1:0] a_d;
  logic             push, pop, empty;

  // Full blocks writes even when a pop happens in the same cycle.
  assign o_ready = (count != CW'(DEPTH));
  assign empty   = (count == '0);
  assign push    = i_valid && o_ready;
  assign pop     = (state == StRun) && !empty;

  assign o_busy  = (state == StRun);
  assign o_done  = (state == StDone);

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Burst sequencing: next state, remaining length, issued operand, bubble count.
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    bubbles_d   = o_bubbles;
    a_d         = '0;
    unique case (state)
      StIdle: begin
        if (i_start) begin
          remaining_d = i_len;
          bubbles_d   = 8'd0;
          state_d     = (i_len == 8'd0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (pop) begin
          a_d         = mem[rd_ptr];
          remaining_d = remaining - 8'd1;
          if (remaining == 8'd1) begin
            state_d = StDone;
          end
        end else if (o_bubbles != 8'hFF) begin
          bubbles_d = o_bubbles + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset aborts any burst without a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= StIdle;
      remaining <= 8'd0;
      o_a       <= '0;
      o_bubbles <= 8'd0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      o_a       <= a_d;
      o_bubbles <= bubbles_d;
    end
  end

endmodule

// File: tb/tb_acc_operand_feeder.sv
// Self-checking bench for acc_operand_feeder: a queue-based reference model
// runs alongside every cycle, plus a constant vector table and directed bursts.
module tb_acc_operand_feeder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       start = 1'b0;
  logic [7:0] len = 8'h00;
  logic       ready;
  logic [7:0] a;
  logic       busy;
  logic       done;
  logic [7:0] bubbles;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue plus burst phase (0 idle, 1 running, 2 finishing).
  int m_q[$];
  int m_phase = 0;
  int m_rem = 0;
  int m_a = 0;
  int m_bub = 0;

  logic [7:0] acc_sum = 8'h00;
  int popped[$];

  acc_operand_feeder #(.DEPTH(DEPTH), .WIDTH(8)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (valid),
    .i_data    (data),
    .o_ready   (ready),
    .i_start   (start),
    .i_len     (len),
    .o_a       (a),
    .o_busy    (busy),
    .o_done    (done),
    .o_bubbles (bubbles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    int issued;
    if (rst) begin
      m_q.delete();
      m_phase = 0;
      m_rem = 0;
      m_a = 0;
      m_bub = 0;
    end else begin
      bit can_write;
      bit take;
      can_write = (m_q.size() != DEPTH);
      take = (m_phase == 1) && (m_q.size() > 0);
      issued = 0;
      if (take) issued = m_q.pop_front();
      if (valid && can_write) m_q.push_back(int'(data));
      m_a = issued;
      case (m_phase)
        0: if (start) begin
          m_rem = int'(len);
          m_bub = 0;
          m_phase = (len == 0) ? 2 : 1;
        end
        1: if (take) begin
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end else if (m_bub < 255) begin
          m_bub++;
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  // One clock: update model, let the edge happen, compare all outputs 1 time unit later.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("o_a", int'(a), m_a);
    chk("o_busy", int'(busy), int'(m_phase == 1));
    chk("o_done", int'(done), int'(m_phase == 2));
    chk("o_bubbles", int'(bubbles), m_bub);
    chk("o_ready", int'(ready), int'(m_q.size() != DEPTH));
    acc_sum = acc_sum + a;
    if (a != 8'h00) popped.push_back(int'(a));
  endtask

  task automatic drive(input bit v, input int d, input bit s, input int l);
    valid = v;
    data = 8'(d);
    start = s;
    len = 8'(l);
  endtask

  typedef struct {
    bit v;
    int d;
    bit s;
    int l;
    int exp_a;
    bit exp_busy;
    bit exp_done;
    bit exp_ready;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Fill and burst, expectations written out by hand.
    vecs[0] = '{1, 'h11, 0, 0, 'h00, 0, 0, 1};
    vecs[1] = '{1, 'h22, 0, 0, 'h00, 0, 0, 1};
    vecs[2] = '{1, 'h33, 0, 0, 'h00, 0, 0, 1};
    vecs[3] = '{1, 'h44, 0, 0, 'h00, 0, 0, 0};
    vecs[4] = '{0, 'h00, 1, 4, 'h00, 1, 0, 0};
    vecs[5] = '{0, 'h00, 0, 0, 'h11, 1, 0, 1};
    vecs[6] = '{0, 'h00, 0, 0, 'h22, 1, 0, 1};
    vecs[7] = '{0, 'h00, 0, 0, 'h33, 1, 0, 1};
    vecs[8] = '{0, 'h00, 0, 0, 'h44, 0, 1, 1};
    vecs[9] = '{0, 'h00, 0, 0, 'h00, 0, 0, 1};

    // Reset with valid and start held high.
    rst = 1'b1;
    drive(1, 'h5A, 1, 3);
    cycle();
    cycle();
    chk("rst_a", int'(a), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bubbles", int'(bubbles), 0);
    rst = 1'b0;
    drive(0, 0, 0, 0);

    acc_sum = 8'h00;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].s, vecs[i].l);
      cycle();
      chk("vec_a", int'(a), vecs[i].exp_a);
      chk("vec_busy", int'(busy), int'(vecs[i].exp_busy));
      chk("vec_done", int'(done), int'(vecs[i].exp_done));
      chk("vec_ready", int'(ready), int'(vecs[i].exp_ready));
    end
    chk("acc_sum", int'(acc_sum), 'hAA);

    // Underflow: empty FIFO, operands arrive late.
    drive(0, 0, 1, 3);
    cycle();
    drive(0, 0, 0, 0);
    cycle();
    cycle();
    drive(1, 'h05, 0, 0);
    cycle();
    chk("uf_bubbles", int'(bubbles), 3);
    drive(1, 'h06, 0, 0);
    cycle();
    chk("uf_a0", int'(a), 'h05);
    drive(1, 'h07, 0, 0);
    cycle();
    chk("uf_a1", int'(a), 'h06);
    drive(0, 0, 0, 0);
    cycle();
    chk("uf_a2", int'(a), 'h07);
    chk("uf_done", int'(done), 1);
    cycle();

    // Zero length with two entries queued.
    drive(1, 'hC1, 0, 0);
    cycle();
    drive(1, 'hC2, 0, 0);
    cycle();
    drive(0, 0, 1, 0);
    cycle();
    chk("zl_done", int'(done), 1);
    chk("zl_a", int'(a), 0);
    drive(0, 0, 1, 2);
    cycle();
    chk("zl_idle", int'(busy), 0);
    cycle();
    drive(0, 0, 0, 0);
    cycle();
    chk("zl_first", int'(a), 'hC1);
    cycle();
    chk("zl_second", int'(a), 'hC2);
    cycle();

    // Wrap and concurrency: stream 1..10 during a 10-long burst, stray start mid-burst.
    popped.delete();
    for (int i = 1; i <= 10; i++) begin
      drive(1, i, (i == 1) || (i == 5), 10);
      cycle();
    end
    drive(0, 0, 0, 0);
    for (int i = 0; i < 20 && !done; i++) cycle();
    chk("wrap_done", int'(done), 1);
    cycle();
    chk("wrap_count", popped.size(), 10);
    for (int i = 0; i < popped.size() && i < 10; i++) chk("wrap_order", popped[i], i + 1);

    // Reset after two of four pops.
    for (int i = 0; i < 4; i++) begin
      drive(1, 'h90 + i, 0, 0);
      cycle();
    end
    drive(0, 0, 1, 4);
    cycle();
    drive(0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mr_a", int'(a), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_done", int'(done), 0);
    cycle();
    chk("mr_nodone", int'(done), 0);
    drive(0, 0, 1, 1);
    cycle();
    drive(0, 0, 0, 0);
    cycle();
    chk("mr_empty_bubble", int'(bubbles), 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 255)),
            $urandom_range(0, 5) == 0, int'($urandom_range(0, 6)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
